pll_reset_sequencer: RTL and testbench

Controls the system PLL's reset and lock bring-up, all in the refclk domain. Holds the PLL in reset for a fixed time, then waits for lock with a timeout and retry limit, and requires lock to stay stable for a qualification window. It then releases one reset per downstream clock domain in a staged order. On loss of lock it re-asserts every downstream reset and re-sequences the PLL.

---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/pll_seq_sync.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset/lock bring-up sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } seq_state_e;

  localparam int DEF_PLL_RST_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT       = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_NUM_DOMAINS        = 3;
  localparam int DEF_STAGE_GAP          = 8;
  localparam int DEF_MAX_RETRIES        = 3;
  localparam int DEF_CNT_W              = 17;

  localparam int LLC_W = 8;

endpackage

// File: rtl/pll_seq_sync.sv
// Two-flop synchronizer bringing an asynchronous level into the refclk domain.
module pll_seq_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock bring-up with timeout/retry, lock qualification and staged
// release of per-domain resets; any lock loss after release re-sequences the PLL.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int NUM_DOMAINS        = DEF_NUM_DOMAINS,
  parameter int STAGE_GAP          = DEF_STAGE_GAP,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
  parameter int CNT_W              = DEF_CNT_W
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   soft_reset_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   sys_ready,
  output logic                   seq_fail,
  output logic [LLC_W-1:0]       lock_loss_count,
  output logic [2:0]             seq_state
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   REL_LAST    = CNT_W'(STAGE_GAP * NUM_DOMAINS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [LLC_W-1:0]       llc_q, llc_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   sys_ready_q, sys_ready_d;
  logic                   seq_fail_q, seq_fail_d;
  logic                   locked_s;
  logic                   lock_lost;

  function automatic logic [LLC_W-1:0] sat_inc(input logic [LLC_W-1:0] v);
    return (v == {LLC_W{1'b1}}) ? v : v + LLC_W'(1);
  endfunction

  // Bit i stays in reset until STAGE_GAP*(i+1) cycles into RELEASE.
  function automatic logic [NUM_DOMAINS-1:0] release_mask(input logic [CNT_W-1:0] cnt);
    logic [NUM_DOMAINS-1:0] m;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      m[i] = (cnt < CNT_W'(STAGE_GAP * (i + 1)));
    end
    return m;
  endfunction

  pll_seq_sync u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  assign lock_lost = !locked_s && (state_q == ST_RELEASE || state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    llc_d   = llc_q;

    if (soft_reset_req) begin
      state_d = ST_PLL_RESET;
      cnt_d   = '0;
      if (state_q == ST_FAIL) retry_d = '0;
    end else if (lock_lost) begin
      state_d = ST_PLL_RESET;
      cnt_d   = '0;
      llc_d   = sat_inc(llc_q);
    end else begin
      unique case (state_q)
        ST_PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_PLL_RESET;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABILIZE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == REL_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          retry_d = '0;
          cnt_d   = '0;
        end
        ST_FAIL: cnt_d = '0;
        default: begin
          state_d = ST_PLL_RESET;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they change with seq_state.
    pll_rst_d   = (state_d == ST_PLL_RESET) || (state_d == ST_FAIL);
    seq_fail_d  = (state_d == ST_FAIL);
    sys_ready_d = (state_d == ST_RUN);
    if (state_d == ST_RELEASE)  domain_rst_d = release_mask(cnt_d);
    else if (state_d == ST_RUN) domain_rst_d = '0;
    else                        domain_rst_d = '1;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PLL_RESET;
      cnt_q        <= '0;
      retry_q      <= '0;
      llc_q        <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= '1;
      sys_ready_q  <= 1'b0;
      seq_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      llc_q        <= llc_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      sys_ready_q  <= sys_ready_d;
      seq_fail_q   <= seq_fail_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign domain_rst      = domain_rst_q;
  assign sys_ready       = sys_ready_q;
  assign seq_fail        = seq_fail_q;
  assign lock_loss_count = llc_q;
  assign seq_state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       sys_ready;
  logic       seq_fail;
  logic [7:0] lock_loss_count;
  logic [2:0] seq_state;

  int checks   = 0;
  int failures = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (32),
    .LOCK_STABLE_CYCLES (8),
    .NUM_DOMAINS        (3),
    .STAGE_GAP          (2),
    .MAX_RETRIES        (2),
    .CNT_W              (17)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .soft_reset_req  (soft_reset_req),
    .pll_rst         (pll_rst),
    .domain_rst      (domain_rst),
    .sys_ready       (sys_ready),
    .seq_fail        (seq_fail),
    .lock_loss_count (lock_loss_count),
    .seq_state       (seq_state)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (seq_state !== s && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    assert (seq_state === s) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (timeout)", tag, seq_state, s);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},  32'(seq_state),       0);
    chk({tag, "_pllrst"}, 32'(pll_rst),         1);
    chk({tag, "_dom"},    32'(domain_rst),      7);
    chk({tag, "_ready"},  32'(sys_ready),       0);
    chk({tag, "_fail"},   32'(seq_fail),        0);
    chk({tag, "_llc"},    32'(lock_loss_count), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    tick(3);
    chk_reset_values("rst");

    // Clean bring-up: lock raised after edge 10.
    rst = 1'b0;
    tick(3);
    chk("up_pllrst_e3", 32'(pll_rst), 1);
    chk("up_state_e3",  32'(seq_state), 0);
    tick(1);
    chk("up_pllrst_e4", 32'(pll_rst), 0);
    chk("up_state_e4",  32'(seq_state), 1);
    tick(6);
    pll_locked = 1'b1;
    tick(3);
    chk("up_stab",      32'(seq_state), 2);
    chk("up_dom_stab",  32'(domain_rst), 7);
    tick(8);
    chk("up_rel",       32'(seq_state), 3);
    chk("up_dom_rel0",  32'(domain_rst), 7);
    tick(2);
    chk("up_dom_110",   32'(domain_rst), 6);
    chk("up_ready_110", 32'(sys_ready), 0);
    tick(2);
    chk("up_dom_100",   32'(domain_rst), 4);
    tick(1);
    chk("up_dom_100b",  32'(domain_rst), 4);
    chk("up_state_100b", 32'(seq_state), 3);
    tick(1);
    chk("up_dom_000",   32'(domain_rst), 0);
    chk("up_ready",     32'(sys_ready), 1);
    chk("up_run",       32'(seq_state), 4);

    // Loss in RUN: domain_rst reasserts exactly 3 edges after the fall.
    tick(1);
    pll_locked = 1'b0;
    tick(2);
    chk("loss_dom_e2",   32'(domain_rst), 0);
    chk("loss_ready_e2", 32'(sys_ready), 1);
    tick(1);
    chk("loss_dom_e3",   32'(domain_rst), 7);
    chk("loss_ready_e3", 32'(sys_ready), 0);
    chk("loss_llc",      32'(lock_loss_count), 1);
    chk("loss_state",    32'(seq_state), 0);
    tick(3);
    chk("loss_pllrst_4th", 32'(pll_rst), 1);
    tick(1);
    chk("loss_pllrst_off", 32'(pll_rst), 0);
    chk("loss_wait",       32'(seq_state), 1);
    pll_locked = 1'b1;

    // One-cycle lock glitch five cycles into STABILIZE.
    tick(3);
    chk("gl_stab", 32'(seq_state), 2);
    tick(4);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    chk("gl_stab_hold", 32'(seq_state), 2);
    tick(1);
    chk("gl_back_wait", 32'(seq_state), 1);
    chk("gl_dom",       32'(domain_rst), 7);
    chk("gl_llc",       32'(lock_loss_count), 1);
    tick(1);
    chk("gl_restab",    32'(seq_state), 2);
    tick(8);
    chk("gl_rel",       32'(seq_state), 3);
    tick(6);
    chk("gl_run",       32'(seq_state), 4);
    chk("gl_run_dom",   32'(domain_rst), 0);
    chk("gl_run_ready", 32'(sys_ready), 1);

    // Timeouts then FAIL; soft reset recovers.
    pll_locked = 1'b0;
    tick(3);
    chk("to_loss_state", 32'(seq_state), 0);
    chk("to_loss_llc",   32'(lock_loss_count), 2);
    tick(4);
    chk("to_wait1",      32'(seq_state), 1);
    tick(31);
    chk("to_wait1_end",  32'(seq_state), 1);
    tick(1);
    chk("to_retry1",     32'(seq_state), 0);
    chk("to_retry1_pll", 32'(pll_rst), 1);
    tick(4);
    chk("to_wait2",      32'(seq_state), 1);
    tick(31);
    chk("to_wait2_end",  32'(seq_state), 1);
    chk("to_nofail",     32'(seq_fail), 0);
    tick(1);
    chk("fail_state",    32'(seq_state), 5);
    chk("fail_flag",     32'(seq_fail), 1);
    chk("fail_pllrst",   32'(pll_rst), 1);
    chk("fail_dom",      32'(domain_rst), 7);
    tick(5);
    chk("fail_stays",    32'(seq_state), 5);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    pll_locked     = 1'b1;
    chk("soft_state",  32'(seq_state), 0);
    chk("soft_fail",   32'(seq_fail), 0);
    chk("soft_pllrst", 32'(pll_rst), 1);
    chk("soft_llc",    32'(lock_loss_count), 2);

    // Async reset in the middle of RELEASE.
    tick(4);
    chk("ar_wait", 32'(seq_state), 1);
    tick(1);
    chk("ar_stab", 32'(seq_state), 2);
    tick(8);
    chk("ar_rel",  32'(seq_state), 3);
    tick(2);
    chk("ar_dom_110", 32'(domain_rst), 6);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("async");
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("re_pllrst_e3", 32'(pll_rst), 1);
    chk("re_state_e3",  32'(seq_state), 0);
    tick(1);
    chk("re_pllrst_e4", 32'(pll_rst), 0);
    chk("re_wait",      32'(seq_state), 1);
    tick(1);
    chk("re_stab",      32'(seq_state), 2);
    tick(8);
    chk("re_rel",       32'(seq_state), 3);
    chk("re_rel_dom",   32'(domain_rst), 7);
    tick(6);
    chk("re_run",       32'(seq_state), 4);
    chk("re_run_dom",   32'(domain_rst), 0);
    chk("re_run_ready", 32'(sys_ready), 1);

    // Drive 260 loss events; counter must saturate at 255.
    for (int k = 1; k <= 260; k++) begin
      pll_locked = 1'b0;
      wait_state(3'd0, 10, "sat_to_reset");
      pll_locked = 1'b1;
      wait_state(3'd4, 40, "sat_to_run");
      if (k == 254) chk("sat_llc_254", 32'(lock_loss_count), 254);
      if (k == 255) chk("sat_llc_255", 32'(lock_loss_count), 255);
      if (k == 260) chk("sat_llc_260", 32'(lock_loss_count), 255);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
